// File: rtl/pipeline_adder_collector.sv
// rtl/pipeline_adder_collector.sv - credit-tracked collector for a pipelined adder, FWFT result FIFO
// Tracks issued operations through the adder latency and buffers sum/cout in issue order.
module pipeline_adder_collector #(
   parameter int WIDTH   = 64,
   parameter int LATENCY = 2,
   parameter int DEPTH   = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           sum_in,
   input  logic                       cout_in,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_sum,
   output logic                       out_cout,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       ovf_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [LATENCY-1:0] r_vpipe;
   logic [CW-1:0]      r_credits;
   logic [CW-1:0]      r_count;
   logic [PW-1:0]      r_wptr;
   logic [PW-1:0]      r_rptr;
   logic [WIDTH:0]     r_mem [DEPTH];
   logic               r_ovf;

   logic               w_issue;
   logic               w_pop;
   logic               w_wr;
   logic               w_full;
   logic               w_wr_ok;
   logic [WIDTH:0]     w_head;

   assign w_issue = in_valid & in_ready;
   assign w_pop   = out_valid & out_ready;
   assign w_wr    = r_vpipe[LATENCY-1];
   assign w_full  = (r_count == CW'(DEPTH));
   assign w_wr_ok = w_wr & (~w_full | w_pop);
   assign w_head  = r_mem[r_rptr];

   // in_ready depends only on registered credits, never on in_valid/out_ready
   assign in_ready  = (r_credits != '0);
   assign out_valid = (r_count != '0);
   assign out_sum   = out_valid ? w_head[WIDTH-1:0] : '0;
   assign out_cout  = out_valid ? w_head[WIDTH] : 1'b0;
   assign count     = r_count;
   assign ovf_err   = r_ovf;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_vpipe <= '0;
      end else begin
         r_vpipe[0] <= w_issue;
         for (int i = 1; i < LATENCY; i++) begin
            r_vpipe[i] <= r_vpipe[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_credits <= CW'(DEPTH);
      end else begin
         case ({w_issue, w_pop})
            2'b10:   r_credits <= r_credits - CW'(1);
            2'b01:   r_credits <= r_credits + CW'(1);
            default: r_credits <= r_credits;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_wr_ok) begin
            r_wptr <= r_wptr + PW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PW'(1);
         end
         case ({w_wr_ok, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         if (w_wr & ~w_wr_ok) begin
            r_ovf <= 1'b1;
         end
      end
   end

   // Storage is not reset; the head is masked to zero while empty
   always_ff @(posedge clk) begin
      if (w_wr_ok) begin
         r_mem[r_wptr] <= {cout_in, sum_in};
      end
   end

endmodule

// File: tb/tb_pipeline_adder_collector.sv
// tb/tb_pipeline_adder_collector.sv - directed and random checks for pipeline_adder_collector
// Drives a behavioural LATENCY-stage adder ahead of the collector and tracks issues in a queue.
module tb_pipeline_adder_collector;

   localparam int WIDTH   = 64;
   localparam int LATENCY = 2;
   localparam int DEPTH   = 4;
   localparam int CW      = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [WIDTH-1:0]  sum_in;
   logic              cout_in;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [WIDTH-1:0]  out_sum;
   logic              out_cout;
   logic [CW-1:0]     count;
   logic              ovf_err;

   logic [WIDTH-1:0]  a = '0;
   logic [WIDTH-1:0]  b = '0;
   logic              cin = 1'b0;
   logic [WIDTH:0]    r_stg [LATENCY];
   logic [WIDTH:0]    sbq [$];

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      r_stg[0] <= {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      for (int i = 1; i < LATENCY; i++) r_stg[i] <= r_stg[i-1];
   end
   assign sum_in  = r_stg[LATENCY-1][WIDTH-1:0];
   assign cout_in = r_stg[LATENCY-1][WIDTH];

   pipeline_adder_collector #(.WIDTH(WIDTH), .LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .sum_in(sum_in), .cout_in(cout_in), .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_cout(out_cout), .count(count), .ovf_err(ovf_err)
   );

   // Bookkeeping only: record issue/pop at this cycle, then advance one clock
   task automatic tick();
      bit iss, pp;
      iss = in_valid && in_ready && !rst;
      pp  = out_valid && out_ready && !rst;
      if (iss) sbq.push_back({1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin});
      if (pp && sbq.size() > 0) void'(sbq.pop_front());
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
      sbq.delete();
      checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else passes++;
      checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else passes++;
      checks++; if (count !== '0) $display("FAIL reset_count got=%0d exp=0", count); else passes++;
      checks++; if (ovf_err !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", ovf_err); else passes++;
      checks++; if ({out_cout, out_sum} !== '0) $display("FAIL reset_out_sum got=%h exp=0", {out_cout, out_sum}); else passes++;
   endtask

   task automatic test_single_op();
      a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'd1; cin = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) $display("FAIL single_early1 got=%b exp=0", out_valid); else passes++;
      tick();
      checks++; if (out_valid !== 1'b0) $display("FAIL single_early2 got=%b exp=0", out_valid); else passes++;
      tick();
      checks++; if (out_valid !== 1'b1) $display("FAIL single_valid got=%b exp=1", out_valid); else passes++;
      checks++; if (out_sum !== 64'd0 || out_cout !== 1'b1)
         $display("FAIL single_data got=%b_%h exp=1_0", out_cout, out_sum); else passes++;
      checks++; if (count !== CW'(1)) $display("FAIL single_count got=%0d exp=1", count); else passes++;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++; if (count !== '0 || out_valid !== 1'b0)
         $display("FAIL single_pop got=count %0d valid %b exp=0 0", count, out_valid); else passes++;
   endtask

   task automatic test_boundary();
      int n;
      a = 64'h8000_0000_0000_0000; b = 64'h8000_0000_0000_0000; cin = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 10) begin tick(); n++; end
      checks++; if (out_valid !== 1'b1) $display("FAIL boundary_timeout got=%b exp=1", out_valid); else passes++;
      checks++; if (out_sum !== 64'd1 || out_cout !== 1'b1)
         $display("FAIL boundary_data got=%b_%h exp=1_1", out_cout, out_sum); else passes++;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_fill();
      int k = 0;
      bit issued;
      out_ready = 1'b0; in_valid = 1'b1;
      for (int c = 0; c < 6; c++) begin
         a = 64'h100 + 64'(k); b = 64'(k); cin = 1'b0;
         checks++; if (in_ready !== (c < 4)) $display("FAIL fill_in_ready c=%0d got=%b exp=%b", c, in_ready, c < 4); else passes++;
         issued = in_ready;
         tick();
         if (issued) k++;
      end
      in_valid = 1'b0;
      tick(); tick(); tick();
      checks++; if (count !== CW'(DEPTH)) $display("FAIL fill_count got=%0d exp=%0d", count, DEPTH); else passes++;
      checks++; if (ovf_err !== 1'b0) $display("FAIL fill_ovf got=%b exp=0", ovf_err); else passes++;
      checks++; if (in_ready !== 1'b0) $display("FAIL fill_ready_low got=%b exp=0", in_ready); else passes++;
      checks++; if (out_sum !== 64'h100) $display("FAIL fill_head got=%h exp=100", out_sum); else passes++;
   endtask

   task automatic test_stream();
      int pops = 0;
      int k = 10;
      logic [WIDTH:0] exp;
      out_ready = 1'b1; in_valid = 1'b1;
      a = 64'h2000 + 64'(k); b = 64'(3 * k); cin = k[0];
      for (int c = 0; c < 20; c++) begin
         checks++; if (in_ready !== (sbq.size() < DEPTH))
            $display("FAIL stream_in_ready c=%0d got=%b exp=%b", c, in_ready, sbq.size() < DEPTH); else passes++;
         checks++; if (count > CW'(DEPTH)) $display("FAIL stream_count c=%0d got=%0d exp<=%0d", c, count, DEPTH); else passes++;
         if (out_valid) begin
            pops++;
            exp = (sbq.size() > 0) ? sbq[0] : 'x;
            checks++; if ({out_cout, out_sum} !== exp)
               $display("FAIL stream_data c=%0d got=%h exp=%h", c, {out_cout, out_sum}, exp); else passes++;
         end
         if (in_ready) begin
            tick();
            k++; a = 64'h2000 + 64'(k); b = 64'(3 * k); cin = k[0];
         end else tick();
      end
      checks++; if (pops != 20) $display("FAIL stream_rate got=%0d exp=20", pops); else passes++;
      in_valid = 1'b0;
      for (int c = 0; c < 8; c++) begin
         if (out_valid) begin
            exp = (sbq.size() > 0) ? sbq[0] : 'x;
            checks++; if ({out_cout, out_sum} !== exp)
               $display("FAIL stream_drain c=%0d got=%h exp=%h", c, {out_cout, out_sum}, exp); else passes++;
         end
         tick();
      end
      checks++; if (count !== '0 || sbq.size() != 0)
         $display("FAIL stream_empty got=count %0d model %0d exp=0 0", count, sbq.size()); else passes++;
      out_ready = 1'b0;
   endtask

   task automatic test_reset_midflight();
      out_ready = 1'b0;
      a = 64'h55; b = 64'h11; cin = 1'b0; in_valid = 1'b1;
      checks++; if (in_ready !== 1'b1) $display("FAIL midrst_ready0 got=%b exp=1", in_ready); else passes++;
      tick();
      a = 64'h66;
      tick();
      in_valid = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
      sbq.delete();
      for (int c = 0; c < 6; c++) begin
         checks++; if (out_valid !== 1'b0) $display("FAIL midrst_valid c=%0d got=%b exp=0", c, out_valid); else passes++;
         tick();
      end
      checks++; if (in_ready !== 1'b1) $display("FAIL midrst_ready got=%b exp=1", in_ready); else passes++;
      checks++; if (count !== '0) $display("FAIL midrst_count got=%0d exp=0", count); else passes++;
      checks++; if (out_sum !== '0) $display("FAIL midrst_out_sum got=%h exp=0", out_sum); else passes++;
   endtask

   task automatic test_random();
      bit hold = 1'b0;
      logic [WIDTH:0] exp;
      for (int c = 0; c < 10000; c++) begin
         if (!hold) begin
            a = {$urandom, $urandom}; b = {$urandom, $urandom}; cin = 1'($urandom);
            in_valid = 1'($urandom_range(0, 1));
         end
         out_ready = ($urandom_range(0, 3) != 0);
         checks++; if (in_ready !== (sbq.size() < DEPTH))
            $display("FAIL random_in_ready c=%0d got=%b exp=%b", c, in_ready, sbq.size() < DEPTH); else passes++;
         if (out_valid && out_ready) begin
            exp = (sbq.size() > 0) ? sbq[0] : 'x;
            checks++; if ({out_cout, out_sum} !== exp)
               $display("FAIL random_data c=%0d got=%h exp=%h", c, {out_cout, out_sum}, exp); else passes++;
         end
         hold = in_valid && !in_ready;
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         if (out_valid) begin
            exp = (sbq.size() > 0) ? sbq[0] : 'x;
            checks++; if ({out_cout, out_sum} !== exp)
               $display("FAIL random_drain c=%0d got=%h exp=%h", c, {out_cout, out_sum}, exp); else passes++;
         end
         tick();
      end
      checks++; if (sbq.size() != 0 || count !== '0)
         $display("FAIL random_leftover got=model %0d count %0d exp=0 0", sbq.size(), count); else passes++;
      checks++; if (ovf_err !== 1'b0) $display("FAIL random_ovf got=%b exp=0", ovf_err); else passes++;
      out_ready = 1'b0;
   endtask

   initial begin
      @(posedge clk); #1;
      test_reset();
      test_single_op();
      test_boundary();
      test_fill();
      test_stream();
      test_reset_midflight();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
